// File: rtl/param_arbiter.sv
// param_arbiter
//   Request arbiter with a two-state (IDLE/HOLD) grant FSM. Selection is
//   fixed priority (lowest index wins) or round-robin starting after the last
//   granted requester. An optional hold limit forces the owner to release
//   after MAX_HOLD consecutive grant cycles. All outputs are registered.
//
// Parameters
//   N        : number of requesters (2..16)
//   RR_MODE  : 0 = fixed priority, 1 = round-robin
//   MAX_HOLD : max consecutive grant cycles, 0 = unlimited (0..255)
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : level requests, bit i = requester i
//   gnt       : one-hot grant or all-zero
//   gnt_valid : high iff gnt is non-zero
//   gnt_idx   : index of the granted requester, 0 when nothing is granted
//   timeout   : one-cycle pulse following a forced release
module param_arbiter #(
  parameter int N        = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 0,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg,   state_next;
  logic [N-1:0]     gnt_reg,     gnt_next;
  logic             valid_reg,   valid_next;
  logic [IDX_W-1:0] idx_reg,     idx_next;
  logic             timeout_reg, timeout_next;
  logic [7:0]       hold_reg,    hold_next;
  logic [IDX_W-1:0] ptr_reg,     ptr_next;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  int               cand;

  // Winner selection. Round-robin scans ptr+1, ptr+2, ... wrapping at N-1,
  // so the last owner is considered last.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!win_found && req[IDX_W'(i)]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = int'(ptr_reg) + k;
        if (cand >= N) cand = cand - N;
        if (!win_found && req[IDX_W'(cand)]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(cand);
        end
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    valid_next   = valid_reg;
    idx_next     = idx_reg;
    timeout_next = 1'b0;
    hold_next    = hold_reg;
    ptr_next     = ptr_reg;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next        = HOLD;
          gnt_next          = '0;
          gnt_next[win_idx] = 1'b1;
          valid_next        = 1'b1;
          idx_next          = win_idx;
          hold_next         = 8'd1;
          ptr_next          = win_idx;
        end
      end
      HOLD: begin
        // A dropped request takes precedence over the hold limit, so a
        // release on the limit edge is reported as a normal release.
        if (!req[idx_reg] ||
            ((MAX_HOLD != 0) && (hold_reg == MAX_HOLD_C))) begin
          state_next   = IDLE;
          gnt_next     = '0;
          valid_next   = 1'b0;
          idx_next     = '0;
          hold_next    = 8'd0;
          timeout_next = req[idx_reg];
        end else if (hold_reg != 8'hff) begin
          hold_next = hold_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      valid_reg   <= 1'b0;
      idx_reg     <= '0;
      timeout_reg <= 1'b0;
      hold_reg    <= 8'd0;
      ptr_reg     <= IDX_W'(N - 1);
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      valid_reg   <= valid_next;
      idx_reg     <= idx_next;
      timeout_reg <= timeout_next;
      hold_reg    <= hold_next;
      ptr_reg     <= ptr_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = valid_reg;
  assign gnt_idx   = idx_reg;
  assign timeout   = timeout_reg;

endmodule

// File: doc/param_arbiter.md
PARAM_ARBITER -- requirements
Module: param_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, number of requesters, legal range 2..16.
REQ-002 The block SHALL have parameter RR_MODE, default 1: 0 = fixed priority, 1 = round-robin.
REQ-003 The block SHALL have parameter MAX_HOLD, default 0: maximum consecutive grant cycles, 0 = unlimited, legal range 0..255.
REQ-004 The block SHALL have derived width IDX_W = max(1, ceil(log2(N))).
REQ-005 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-007 Port req SHALL be an input, N bits: level requests, bit i = requester i.
REQ-008 Port gnt SHALL be an output, N bits: registered one-hot grant, or all-zero.
REQ-009 Port gnt_valid SHALL be an output, 1 bit: registered; high iff gnt is non-zero.
REQ-010 Port gnt_idx SHALL be an output, IDX_W bits: registered index of the granted requester, 0 when gnt_valid is low.
REQ-011 Port timeout SHALL be an output, 1 bit: registered single-cycle pulse on a forced release.

Function
REQ-012 The FSM SHALL have two states: IDLE (no grant) and HOLD (one owner granted).
REQ-013 In IDLE with req non-zero, the next edge SHALL enter HOLD and assert gnt, gnt_idx and gnt_valid for the selected winner; latency is 1 cycle from request to grant.
REQ-014 In IDLE with req all-zero, the block SHALL remain in IDLE with outputs zero.
REQ-015 With RR_MODE=0, the winner SHALL be the lowest set index of req.
REQ-016 With RR_MODE=1, the winner SHALL be the first set bit searching upward from ptr+1, wrapping from N-1 to 0, where ptr is the index of the last granted requester.
REQ-017 ptr SHALL update to the winner index on every IDLE->HOLD transition.
REQ-018 In HOLD, the grant SHALL persist unchanged while req[owner]=1, regardless of other requests.
REQ-019 In HOLD, on an edge where req[owner]=0, the block SHALL return to IDLE and clear gnt, gnt_idx and gnt_valid.
REQ-020 There SHALL be at least one IDLE cycle between consecutive grants (no back-to-back handover).
REQ-021 hold_cnt (8 bits) SHALL load 1 on grant and increment each HOLD cycle the owner keeps requesting.
REQ-022 With MAX_HOLD>0, on the edge where hold_cnt = MAX_HOLD and req[owner]=1, the block SHALL force a release to IDLE and pulse timeout for exactly 1 cycle.
REQ-023 After a forced release in RR_MODE=1, the rotation from ptr SHALL give other active requesters priority over the previous owner.
REQ-024 After a forced release in RR_MODE=0, the previous owner MAY be re-granted if it remains the lowest set index.
REQ-025 If the owner drops its request on the same edge the timeout would fire, the block SHALL treat it as a normal release with timeout=0.
REQ-026 With MAX_HOLD=0, timeout SHALL never assert.
REQ-027 At most one gnt bit SHALL be high at any time.
REQ-028 gnt_valid SHALL equal |gnt, and gnt_idx SHALL match the set bit of gnt.

Reset
REQ-029 On rst_n low, the block SHALL immediately, without waiting for a clock, force state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, hold_cnt=0 and ptr=N-1, so that index 0 is first in round-robin.
REQ-030 Reset asserted mid-HOLD SHALL drop the grant asynchronously; after deassertion, the first grant SHALL follow REQ-013 with a 1-cycle latency.

Verification
REQ-031 Fixed priority (N=4, RR_MODE=0): req=0110 -> next cycle gnt=0010, gnt_idx=1; raise req[0] while req[1] is held -> gnt stays 0010.
REQ-032 Release and dead cycle: owner 1 drops req, req=0100 -> one cycle gnt=0000, next cycle gnt=0100.
REQ-033 Round-robin (RR_MODE=1): req=1111 held continuously, each owner drops req for one cycle after its grant -> grant order 0,1,2,3,0.
REQ-034 Timeout (MAX_HOLD=8, RR_MODE=1): req=0011 held constantly -> gnt=0001 for 8 cycles, timeout pulses once, 1 idle cycle, then gnt=0010.
REQ-035 Timeout/release collision: owner drops req on the cycle hold_cnt=MAX_HOLD -> normal release, timeout=0.
REQ-036 Asynchronous reset during HOLD (gnt=0100): pulse rst_n low between clock edges -> gnt=0000 with no clock edge; with req=1111 after release -> gnt=0001.
